// File: rtl/uart_pkg.sv
// Register map, STATUS/CTRL bit positions and a count-saturation helper
// shared by the UART bus block.
package uart_pkg;

    localparam logic [1:0] REG_DATA = 2'b00;
    localparam logic [1:0] REG_STAT = 2'b01;
    localparam logic [1:0] REG_CNT  = 2'b10;
    localparam logic [1:0] REG_CTRL = 2'b11;

    localparam int STAT_RX_AVAIL = 0;
    localparam int STAT_RX_FULL  = 2;
    localparam int STAT_TX_EMPTY = 3;
    localparam int STAT_TX_FULL  = 4;
    localparam int STAT_RX_OVR   = 5;
    localparam int STAT_TX_OVR   = 6;
    localparam int STAT_IRQ      = 7;

    localparam int CTRL_RX_IE  = 0;
    localparam int CTRL_TX_IE  = 1;
    localparam int CTRL_OVR_IE = 2;
    localparam int CTRL_W      = 3;

    // FIFO occupancy squeezed into a 4-bit CNT field; a full 16-deep FIFO reads 15.
    function automatic logic [3:0] sat_nibble(input logic [31:0] cnt);
        return (cnt > 32'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two so
// the pointers wrap by natural overflow.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign count = count_reg;
    assign dout  = mem[rd_ptr_reg];

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: samples mid-bit after a validated start bit and
// presents the byte with a one-cycle valid pulse.
module uart_rx #(
    parameter real CLK_FRE   = 25.175,
    parameter int  BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    input  logic       rx_pin
);
    localparam int          CYCLE = int'(CLK_FRE * 1000000.0 / real'(BAUD_RATE));
    localparam logic [15:0] LAST  = 16'(CYCLE - 1);
    localparam logic [15:0] HALF  = 16'(CYCLE / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_RECV, S_STOP, S_DATA} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  sync_reg;
    logic [15:0] cycle_reg, cycle_next;
    logic [2:0]  bit_reg, bit_next;
    logic [7:0]  shift_reg, shift_next;
    logic        rx_s;

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 2'b11;
            state_reg <= S_IDLE;
            cycle_reg <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            sync_reg  <= {sync_reg[0], rx_pin};
            state_reg <= state_next;
            cycle_reg <= cycle_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cycle_next = cycle_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                    cycle_next = '0;
                end
            end
            S_START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (cycle_reg == HALF) begin
                    cycle_next = '0;
                    bit_next   = '0;
                    state_next = rx_s ? S_IDLE : S_RECV;
                end else begin
                    cycle_next = cycle_reg + 16'd1;
                end
            end
            S_RECV: begin
                if (cycle_reg == LAST) begin
                    cycle_next = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    if (bit_reg == 3'd7)
                        state_next = S_STOP;
                    else
                        bit_next = bit_reg + 3'd1;
                end else begin
                    cycle_next = cycle_reg + 16'd1;
                end
            end
            S_STOP: begin
                if (cycle_reg == LAST) begin
                    cycle_next = '0;
                    state_next = S_DATA;
                end else begin
                    cycle_next = cycle_reg + 16'd1;
                end
            end
            default: begin
                if (rx_data_ready)
                    state_next = S_IDLE;
            end
        endcase
    end

    assign rx_data       = shift_reg;
    assign rx_data_valid = (state_reg == S_DATA);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: accepts a byte on valid&ready while idle and shifts it out LSB first.
module uart_tx #(
    parameter real CLK_FRE   = 25.175,
    parameter int  BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin
);
    localparam int          CYCLE = int'(CLK_FRE * 1000000.0 / real'(BAUD_RATE));
    localparam logic [15:0] LAST  = 16'(CYCLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_STOP} state_t;

    state_t      state_reg, state_next;
    logic [15:0] cycle_reg, cycle_next;
    logic [2:0]  bit_reg, bit_next;
    logic [7:0]  shift_reg, shift_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cycle_reg <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            cycle_reg <= cycle_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cycle_next    = cycle_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        tx_data_ready = (state_reg == S_IDLE);
        unique case (state_reg)
            S_IDLE: begin
                if (tx_data_valid) begin
                    state_next = S_START;
                    cycle_next = '0;
                    shift_next = tx_data;
                end
            end
            S_START: begin
                if (cycle_reg == LAST) begin
                    cycle_next = '0;
                    bit_next   = '0;
                    state_next = S_SEND;
                end else begin
                    cycle_next = cycle_reg + 16'd1;
                end
            end
            S_SEND: begin
                if (cycle_reg == LAST) begin
                    cycle_next = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7)
                        state_next = S_STOP;
                    else
                        bit_next = bit_reg + 3'd1;
                end else begin
                    cycle_next = cycle_reg + 16'd1;
                end
            end
            default: begin
                if (cycle_reg == LAST) begin
                    cycle_next = '0;
                    state_next = S_IDLE;
                end else begin
                    cycle_next = cycle_reg + 16'd1;
                end
            end
        endcase
    end

    // Line level is decoded from state so an asynchronous reset idles the line at once.
    assign tx_pin = (state_reg == S_START) ? 1'b0 :
                    (state_reg == S_SEND)  ? shift_reg[0] : 1'b1;

endmodule

// File: rtl/uart_fifo_bus.sv
// CPU-bus UART peripheral: TX/RX FIFOs, status/count/control registers,
// sticky overrun flags and a level interrupt around the uart_rx/uart_tx cores.
module uart_fifo_bus
    import uart_pkg::*;
#(
    parameter real CLK_FRE  = 25.175,
    parameter int  UART_FRE = 115200,
    parameter int  TX_DEPTH = 16,
    parameter int  RX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_i,
    input  logic       uart_cs,
    input  logic       R_W_n,
    input  logic [1:0] reg_addr,
    output logic [7:0] data_o,
    output logic       irq,
    input  logic       uart_rx,
    output logic       uart_tx
);
    localparam int TX_CW = $clog2(TX_DEPTH + 1);
    localparam int RX_CW = $clog2(RX_DEPTH + 1);

    logic              bus_wr, bus_rd;
    logic              tx_push, tx_pop, tx_push_acc, tx_full, tx_empty;
    logic [7:0]        tx_dout;
    logic [TX_CW-1:0]  tx_count;
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]        rx_dout;
    logic [RX_CW-1:0]  rx_count;
    logic              tx_data_valid_reg, tx_data_valid_next;
    logic              tx_data_ready;
    logic [7:0]        rx_data;
    logic              rx_data_valid;
    logic              tx_ovr_reg, tx_ovr_next;
    logic              rx_ovr_reg, rx_ovr_next;
    logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
    logic [7:0]        status;

    assign bus_wr  = uart_cs & ~R_W_n;
    assign bus_rd  = uart_cs & R_W_n;
    assign tx_push = bus_wr & (reg_addr == REG_DATA);
    assign rx_pop  = bus_rd & (reg_addr == REG_DATA);
    assign tx_pop  = tx_data_valid_reg & tx_data_ready;
    assign rx_push = rx_data_valid;
    assign tx_push_acc = tx_push & (~tx_full | tx_pop);

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (data_i),
        .dout  (tx_dout),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    uart_tx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(UART_FRE)) u_uart_tx (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data       (tx_dout),
        .tx_data_valid (tx_data_valid_reg),
        .tx_data_ready (tx_data_ready),
        .tx_pin        (uart_tx)
    );

    uart_rx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(UART_FRE)) u_uart_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (1'b1),
        .rx_pin        (uart_rx)
    );

    // Valid follows non-empty one cycle late, but drops on the handshake that drains the last byte.
    always_comb begin
        tx_data_valid_next = ~tx_empty;
        if (tx_pop)
            tx_data_valid_next = (tx_count != TX_CW'(1)) | tx_push_acc;
    end

    always_comb begin
        tx_ovr_next = tx_ovr_reg;
        rx_ovr_next = rx_ovr_reg;
        ctrl_next   = ctrl_reg;
        if (bus_wr && reg_addr == REG_STAT) begin
            if (data_i[STAT_TX_OVR])
                tx_ovr_next = 1'b0;
            if (data_i[STAT_RX_OVR])
                rx_ovr_next = 1'b0;
        end
        if (bus_wr && reg_addr == REG_CTRL)
            ctrl_next = data_i[CTRL_W-1:0];
        // Setting comes last so a fresh overrun beats a simultaneous clear.
        if (tx_push & tx_full & ~tx_pop)
            tx_ovr_next = 1'b1;
        if (rx_push & rx_full & ~rx_pop)
            rx_ovr_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_valid_reg <= 1'b0;
            tx_ovr_reg        <= 1'b0;
            rx_ovr_reg        <= 1'b0;
            ctrl_reg          <= '0;
        end else begin
            tx_data_valid_reg <= tx_data_valid_next;
            tx_ovr_reg        <= tx_ovr_next;
            rx_ovr_reg        <= rx_ovr_next;
            ctrl_reg          <= ctrl_next;
        end
    end

    assign irq = (ctrl_reg[CTRL_RX_IE]  & ~rx_empty) |
                 (ctrl_reg[CTRL_TX_IE]  & tx_empty)  |
                 (ctrl_reg[CTRL_OVR_IE] & (rx_ovr_reg | tx_ovr_reg));

    always_comb begin
        status                = '0;
        status[STAT_RX_AVAIL] = ~rx_empty;
        status[STAT_RX_FULL]  = rx_full;
        status[STAT_TX_EMPTY] = tx_empty;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_RX_OVR]   = rx_ovr_reg;
        status[STAT_TX_OVR]   = tx_ovr_reg;
        status[STAT_IRQ]      = irq;
    end

    always_comb begin
        data_o = '0;
        unique case (reg_addr)
            REG_DATA: data_o = rx_empty ? 8'h00 : rx_dout;
            REG_STAT: data_o = status;
            REG_CNT:  data_o = {sat_nibble(32'(rx_count)), sat_nibble(32'(tx_count))};
            default:  data_o = {{(8 - CTRL_W){1'b0}}, ctrl_reg};
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_bus.sv
// Directed bench for uart_fifo_bus at 10 clocks per bit: register reset values,
// TX framing and overrun, RX capture/overrun/push-pop, IRQ sources and reset abort.
module tb_uart_fifo_bus;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       uart_cs = 1'b0;
    logic       R_W_n = 1'b1;
    logic [1:0] reg_addr = 2'b00;
    logic       uart_rx = 1'b1;
    logic [7:0] data_o;
    logic       irq;
    logic       uart_tx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_fifo_bus #(
        .CLK_FRE  (1.0),
        .UART_FRE (100000),
        .TX_DEPTH (16),
        .RX_DEPTH (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_i   (data_i),
        .uart_cs  (uart_cs),
        .R_W_n    (R_W_n),
        .reg_addr (reg_addr),
        .data_o   (data_o),
        .irq      (irq),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        uart_cs = 1'b1; R_W_n = 1'b0; reg_addr = a; data_i = d;
        @(negedge clk);
        uart_cs = 1'b0; R_W_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        uart_cs = 1'b1; R_W_n = 1'b1; reg_addr = a;
        #1 d = data_o;
        @(negedge clk);
        uart_cs = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check_eq(tag, 32'(d), 32'(exp));
    endtask

    task automatic send_serial(input logic [7:0] b);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (10) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (9) @(negedge clk);
    endtask

    // Waits (bounded) for a start bit, samples each bit mid-period, returns at mid-stop.
    task automatic get_serial(output logic [7:0] b, output int gap);
        gap = 0;
        b   = 8'h00;
        while (uart_tx !== 1'b0 && gap < 3000) begin
            @(negedge clk);
            gap++;
        end
        check_eq("tx_start_seen", 32'(gap < 3000), 32'd1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (10) @(negedge clk);
        check_eq("tx_stop_bit", 32'(uart_tx), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         gap;

        #1;
        check_eq("reset_uart_tx", 32'(uart_tx), 32'd1);
        check_eq("reset_irq", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Bit 1 of STATUS is reserved and reads zero, so only tx_empty is set.
        read_check("reset_status", 2'b01, 8'h08);
        read_check("reset_ctrl",   2'b11, 8'h00);
        read_check("reset_cnt",    2'b10, 8'h00);
        read_check("reset_rx_data", 2'b00, 8'h00);

        // Three queued bytes leave as back-to-back frames in order.
        fork
            begin
                bus_write(2'b00, 8'h55);
                bus_write(2'b00, 8'hAA);
                bus_write(2'b00, 8'h0F);
            end
            begin
                get_serial(b, gap);
                check_eq("tx_frame0", 32'(b), 32'h55);
                get_serial(b, gap);
                check_eq("tx_frame1", 32'(b), 32'hAA);
                check_eq("tx_gap1", 32'(gap <= 8), 32'd1);
                read_check("tx_status_last_queued", 2'b01, 8'h00);
                get_serial(b, gap);
                check_eq("tx_frame2", 32'(b), 32'h0F);
                check_eq("tx_gap2", 32'(gap <= 8), 32'd1);
            end
        join
        read_check("tx_status_drained", 2'b01, 8'h08);

        // Line held busy by 0xFF, then 17 writes: 16 fit, the 17th overruns.
        repeat (10) @(negedge clk);
        bus_write(2'b00, 8'hFF);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 17; i++)
            bus_write(2'b00, 8'(8'h80 + i));
        read_check("tx_ovr_status", 2'b01, 8'h50);
        read_check("tx_ovr_cnt",    2'b10, 8'h0F);
        bus_write(2'b01, 8'h40);
        read_check("tx_ovr_clear",  2'b01, 8'h10);
        for (int i = 0; i < 16; i++) begin
            get_serial(b, gap);
            check_eq($sformatf("tx_drain%0d", i), 32'(b), 32'h80 + 32'(i));
        end
        repeat (10) @(negedge clk);
        read_check("tx_drain_status", 2'b01, 8'h08);

        // Three received bytes, popped in order, then an empty read.
        send_serial(8'h31);
        send_serial(8'h32);
        send_serial(8'h33);
        repeat (5) @(negedge clk);
        read_check("rx3_cnt",    2'b10, 8'h30);
        read_check("rx3_status", 2'b01, 8'h09);
        read_check("rx3_data0",  2'b00, 8'h31);
        read_check("rx3_data1",  2'b00, 8'h32);
        read_check("rx3_data2",  2'b00, 8'h33);
        read_check("rx_empty_read", 2'b00, 8'h00);
        read_check("rx_empty_cnt",  2'b10, 8'h00);

        // Fill RX, overrun it, exercise the overrun interrupt, then clear.
        for (int i = 0; i < 16; i++)
            send_serial(8'(8'h40 + i));
        repeat (5) @(negedge clk);
        read_check("rx_full_cnt",    2'b10, 8'hF0);
        read_check("rx_full_status", 2'b01, 8'h0D);
        send_serial(8'h99);
        repeat (5) @(negedge clk);
        read_check("rx_ovr_status", 2'b01, 8'h2D);
        read_check("rx_ovr_cnt",    2'b10, 8'hF0);
        bus_write(2'b11, 8'h04);
        check_eq("ovr_irq_set", 32'(irq), 32'd1);
        read_check("ovr_irq_status", 2'b01, 8'hAD);
        bus_write(2'b01, 8'h20);
        check_eq("ovr_irq_clear", 32'(irq), 32'd0);
        read_check("rx_ovr_clear", 2'b01, 8'h0D);
        bus_write(2'b11, 8'h00);

        // Pop on the very cycle the next byte is pushed into the full FIFO.
        fork
            send_serial(8'h50);
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (dut.rx_data_valid !== 1'b1 && n < 400);
                check_eq("rx_push_seen", 32'(n < 400), 32'd1);
                uart_cs = 1'b1; R_W_n = 1'b1; reg_addr = 2'b00;
                #1;
                check_eq("rx_pop_head", 32'(data_o), 32'h40);
                @(negedge clk);
                uart_cs = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        read_check("rx_pushpop_cnt",    2'b10, 8'hF0);
        read_check("rx_pushpop_status", 2'b01, 8'h0D);
        for (int i = 0; i < 16; i++)
            read_check($sformatf("rx_order%0d", i), 2'b00, 8'(8'h41 + i));
        read_check("rx_drained_status", 2'b01, 8'h08);

        // Interrupt sources: RX available, then TX empty.
        bus_write(2'b11, 8'h01);
        check_eq("irq_rx_idle", 32'(irq), 32'd0);
        send_serial(8'h77);
        repeat (5) @(negedge clk);
        check_eq("irq_rx_set", 32'(irq), 32'd1);
        read_check("irq_rx_data", 2'b00, 8'h77);
        check_eq("irq_rx_clear", 32'(irq), 32'd0);
        bus_write(2'b11, 8'h02);
        check_eq("irq_tx_empty", 32'(irq), 32'd1);
        read_check("irq_status", 2'b01, 8'h88);

        // Reset in the middle of a frame idles the line at once.
        bus_write(2'b00, 8'h00);
        repeat (30) @(negedge clk);
        check_eq("abort_line_low", 32'(uart_tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("abort_line_idle", 32'(uart_tx), 32'd1);
        check_eq("abort_irq", 32'(irq), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("abort_line_stays_idle", 32'(uart_tx), 32'd1);
        read_check("abort_status", 2'b01, 8'h08);
        read_check("abort_ctrl",   2'b11, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
